// File: rtl/order_ref_map_pkg.sv
// Shared types for the order-reference lookup stage: table entry layout,
// pipeline message record and the init/run state encoding.
package order_ref_map_pkg;

  localparam int ORDER_REF_BITS = 64;

  typedef enum logic {
    INIT,
    RUN
  } map_state_t;

  typedef enum logic [1:0] {
    MSG_NONE,
    MSG_ADD,
    MSG_EXEC,
    MSG_DEL
  } msg_kind_t;

  // The tag field is sized for the full reference; bits above TAG_BITS are always zero.
  typedef struct packed {
    logic                      valid;
    logic [ORDER_REF_BITS-1:0] tag;
    logic [15:0]               locate;
    logic [31:0]               price;
    logic [31:0]               shares;
    logic                      buy_sell;
  } order_entry_t;

  typedef struct packed {
    msg_kind_t                 kind;
    logic                      err;
    logic [ORDER_REF_BITS-1:0] order_ref;
    logic [15:0]               locate;
    logic [31:0]               price;
    logic [31:0]               shares;
    logic                      buy_sell;
  } msg_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
  endfunction

endpackage

// File: rtl/order_ref_ram.sv
// Order table storage: one write port, one registered read port, read-first.
// No reset so the array maps onto block RAM.
module order_ref_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 1
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/order_ref_map.sv
// Order-reference lookup ahead of order_book: stores live orders by reference and
// recovers their attributes on delete/execute, three cycles input to output.
module order_ref_map
  import order_ref_map_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic        clkIn,
  input  logic        rstIn,
  output logic        readyOut,
  input  logic        addValidIn,
  input  logic        delValidIn,
  input  logic        execValidIn,
  input  logic [63:0] orderRefIn,
  input  logic [15:0] locateIn,
  input  logic [31:0] priceIn,
  input  logic [31:0] sharesIn,
  input  logic        buySellIn,
  output logic        addValidOut,
  output logic [15:0] locateOut,
  output logic [31:0] priceOut,
  output logic [31:0] sharesOut,
  output logic        buySellOut,
  output logic        delExecValidOut,
  output logic [15:0] mapLocateOut,
  output logic [31:0] mapPriceOut,
  output logic [31:0] mapSharesOut,
  output logic        mapBuySellOut,
  output logic [15:0] missCntOut,
  output logic [15:0] collisionCntOut,
  output logic [15:0] errCntOut
);

  localparam int ADDR_BITS  = $clog2(DEPTH);
  localparam int TAG_BITS   = ORDER_REF_BITS - ADDR_BITS;
  localparam int ENTRY_BITS = $bits(order_entry_t);

  // state | meaning
  // INIT  | clearing one table entry per cycle; message valids ignored
  // RUN   | table usable, messages accepted until the next reset
  map_state_t           state_q;
  logic [ADDR_BITS-1:0] init_addr_q;
  logic                 ready_q;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      ready_q     <= 1'b0;
    end else if (state_q == INIT) begin
      init_addr_q <= init_addr_q + ADDR_BITS'(1);
      if (init_addr_q == ADDR_BITS'(DEPTH - 1)) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  msg_t s0_d, s0_q, s1_q;

  always_comb begin
    s0_d = '0;
    if (state_q == RUN) begin
      s0_d.order_ref = orderRefIn;
      s0_d.locate    = locateIn;
      s0_d.price     = priceIn;
      s0_d.shares    = sharesIn;
      s0_d.buy_sell  = buySellIn;
      s0_d.err       = (addValidIn & delValidIn) | (addValidIn & execValidIn) |
                       (delValidIn & execValidIn);
      if (addValidIn)       s0_d.kind = MSG_ADD;
      else if (execValidIn) s0_d.kind = MSG_EXEC;
      else if (delValidIn)  s0_d.kind = MSG_DEL;
    end
  end

  logic [ADDR_BITS-1:0]      s0_idx, s1_idx;
  logic [ORDER_REF_BITS-1:0] s1_tag;
  logic [ENTRY_BITS-1:0]     ram_rdata, ram_wdata;
  logic [ADDR_BITS-1:0]      ram_waddr;
  logic                      ram_we;

  logic                 wb_valid_q;
  logic [ADDR_BITS-1:0] wb_idx_q;
  order_entry_t         wb_data_q;

  order_entry_t cur, wr_data;
  logic         hit, wr_en, add_v, de_v, miss, coll;
  logic [31:0]  map_shares;

  assign s0_idx = s0_q.order_ref[ADDR_BITS-1:0];
  assign s1_idx = s1_q.order_ref[ADDR_BITS-1:0];
  assign s1_tag = ORDER_REF_BITS'(s1_q.order_ref[ORDER_REF_BITS-1 -: TAG_BITS]);

  // The previous write-back has not reached the RAM read data yet, so forward it.
  assign cur = (wb_valid_q && wb_idx_q == s1_idx) ? wb_data_q : order_entry_t'(ram_rdata);
  assign hit = cur.valid && (cur.tag == s1_tag);

  always_comb begin
    wr_en      = 1'b0;
    wr_data    = cur;
    add_v      = 1'b0;
    de_v       = 1'b0;
    miss       = 1'b0;
    coll       = 1'b0;
    map_shares = cur.shares;
    case (s1_q.kind)
      MSG_ADD: begin
        wr_en   = 1'b1;
        add_v   = 1'b1;
        coll    = cur.valid && (cur.tag != s1_tag);
        wr_data = '{valid: 1'b1, tag: s1_tag, locate: s1_q.locate, price: s1_q.price,
                    shares: s1_q.shares, buy_sell: s1_q.buy_sell};
      end
      MSG_EXEC: begin
        if (hit) begin
          wr_en = 1'b1;
          de_v  = 1'b1;
          if (s1_q.shares >= cur.shares) begin
            wr_data.valid = 1'b0;
          end else begin
            wr_data.shares = cur.shares - s1_q.shares;
            map_shares     = s1_q.shares;
          end
        end else begin
          miss = 1'b1;
        end
      end
      MSG_DEL: begin
        if (hit) begin
          wr_en         = 1'b1;
          de_v          = 1'b1;
          wr_data.valid = 1'b0;
        end else begin
          miss = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ram_we    = (state_q == INIT) ? 1'b1 : wr_en;
  assign ram_waddr = (state_q == INIT) ? init_addr_q : s1_idx;
  assign ram_wdata = (state_q == INIT) ? '0 : ENTRY_BITS'(wr_data);

  order_ref_ram #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_BITS)
  ) u_ram (
    .clk_i  (clkIn),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(s0_idx),
    .rdata_o(ram_rdata)
  );

  logic        add_valid_q, de_valid_q;
  logic [15:0] locate_q, map_locate_q;
  logic [31:0] price_q, shares_q, map_price_q, map_shares_q;
  logic        buy_sell_q, map_buy_sell_q;
  logic [15:0] miss_cnt_q, coll_cnt_q, err_cnt_q;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      s0_q           <= '0;
      s1_q           <= '0;
      wb_valid_q     <= 1'b0;
      wb_idx_q       <= '0;
      wb_data_q      <= '0;
      add_valid_q    <= 1'b0;
      de_valid_q     <= 1'b0;
      locate_q       <= '0;
      price_q        <= '0;
      shares_q       <= '0;
      buy_sell_q     <= 1'b0;
      map_locate_q   <= '0;
      map_price_q    <= '0;
      map_shares_q   <= '0;
      map_buy_sell_q <= 1'b0;
      miss_cnt_q     <= '0;
      coll_cnt_q     <= '0;
      err_cnt_q      <= '0;
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s0_q;
      wb_valid_q  <= wr_en;
      wb_idx_q    <= s1_idx;
      wb_data_q   <= wr_data;
      add_valid_q <= add_v;
      de_valid_q  <= de_v;
      if (add_v) begin
        locate_q   <= s1_q.locate;
        price_q    <= s1_q.price;
        shares_q   <= s1_q.shares;
        buy_sell_q <= s1_q.buy_sell;
      end
      if (de_v) begin
        map_locate_q   <= cur.locate;
        map_price_q    <= cur.price;
        map_shares_q   <= map_shares;
        map_buy_sell_q <= cur.buy_sell;
      end
      miss_cnt_q <= sat_inc(miss_cnt_q, miss);
      coll_cnt_q <= sat_inc(coll_cnt_q, coll);
      err_cnt_q  <= sat_inc(err_cnt_q, s1_q.err);
    end
  end

  assign readyOut        = ready_q;
  assign addValidOut     = add_valid_q;
  assign locateOut       = locate_q;
  assign priceOut        = price_q;
  assign sharesOut       = shares_q;
  assign buySellOut      = buy_sell_q;
  assign delExecValidOut = de_valid_q;
  assign mapLocateOut    = map_locate_q;
  assign mapPriceOut     = map_price_q;
  assign mapSharesOut    = map_shares_q;
  assign mapBuySellOut   = map_buy_sell_q;
  assign missCntOut      = miss_cnt_q;
  assign collisionCntOut = coll_cnt_q;
  assign errCntOut       = err_cnt_q;

endmodule

// File: tb/tb_order_ref_map.sv
// Bench for order_ref_map (DEPTH=16): directed vector table, reset/INIT sequences,
// and random traffic checked against a direct-mapped table model.
`timescale 1ns/1ps
module tb_order_ref_map;

  localparam int DEPTH = 16;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic        readyOut;
  logic        addValidIn, delValidIn, execValidIn;
  logic [63:0] orderRefIn;
  logic [15:0] locateIn;
  logic [31:0] priceIn, sharesIn;
  logic        buySellIn;
  logic        addValidOut, buySellOut, delExecValidOut, mapBuySellOut;
  logic [15:0] locateOut, mapLocateOut, missCntOut, collisionCntOut, errCntOut;
  logic [31:0] priceOut, sharesOut, mapPriceOut, mapSharesOut;

  always #5 clkIn = ~clkIn;

  order_ref_map #(.DEPTH(DEPTH)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .readyOut(readyOut),
    .addValidIn(addValidIn), .delValidIn(delValidIn), .execValidIn(execValidIn),
    .orderRefIn(orderRefIn), .locateIn(locateIn), .priceIn(priceIn),
    .sharesIn(sharesIn), .buySellIn(buySellIn),
    .addValidOut(addValidOut), .locateOut(locateOut), .priceOut(priceOut),
    .sharesOut(sharesOut), .buySellOut(buySellOut),
    .delExecValidOut(delExecValidOut), .mapLocateOut(mapLocateOut),
    .mapPriceOut(mapPriceOut), .mapSharesOut(mapSharesOut), .mapBuySellOut(mapBuySellOut),
    .missCntOut(missCntOut), .collisionCntOut(collisionCntOut), .errCntOut(errCntOut)
  );

  typedef struct {
    logic        add_v, exec_v, del_v;
    logic [63:0] oref;
    logic [15:0] loc;
    logic [31:0] price, shares;
    logic        buy;
    logic        e_add, e_de;
    logic [15:0] e_loc;
    logic [31:0] e_price, e_shares;
    logic        e_buy;
    logic [15:0] e_miss, e_coll, e_err;
  } vec_t;

  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_miscmp = 0;
  vec_t tbl[16];
  vec_t stim[$];

  function automatic vec_t msg(input logic a, input logic e, input logic d, input logic [63:0] r,
                               input logic [15:0] l, input logic [31:0] p, input logic [31:0] s,
                               input logic b);
    vec_t v = '{default: 0};
    v.add_v = a; v.exec_v = e; v.del_v = d; v.oref = r;
    v.loc = l; v.price = p; v.shares = s; v.buy = b;
    return v;
  endfunction

  function automatic vec_t expect_v(input vec_t v, input logic ea, input logic ed,
                                    input logic [15:0] l, input logic [31:0] p, input logic [31:0] s,
                                    input logic b, input logic [15:0] m, input logic [15:0] c,
                                    input logic [15:0] er);
    vec_t o = v;
    o.e_add = ea; o.e_de = ed; o.e_loc = l; o.e_price = p; o.e_shares = s; o.e_buy = b;
    o.e_miss = m; o.e_coll = c; o.e_err = er;
    return o;
  endfunction

  // Reference model: direct-mapped table indexed by ref mod DEPTH, matched on the full ref.
  logic        m_live[DEPTH];
  logic [63:0] m_ref[DEPTH];
  logic [15:0] m_loc[DEPTH];
  logic [31:0] m_price[DEPTH], m_sh[DEPTH];
  logic        m_buy[DEPTH];
  int          m_miss, m_coll, m_err;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_live[i] = 1'b0;
    m_miss = 0; m_coll = 0; m_err = 0;
  endfunction

  function automatic logic [15:0] sat16(input int x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  function automatic vec_t model_step(input vec_t v);
    vec_t o = v;
    int   k = int'(v.oref % 64'(DEPTH));
    o.e_add = 0; o.e_de = 0; o.e_loc = 0; o.e_price = 0; o.e_shares = 0; o.e_buy = 0;
    if (int'(v.add_v) + int'(v.exec_v) + int'(v.del_v) > 1) m_err++;
    if (v.add_v) begin
      if (m_live[k] && m_ref[k] != v.oref) m_coll++;
      m_live[k] = 1'b1; m_ref[k] = v.oref; m_loc[k] = v.loc;
      m_price[k] = v.price; m_sh[k] = v.shares; m_buy[k] = v.buy;
      o.e_add = 1; o.e_loc = v.loc; o.e_price = v.price; o.e_shares = v.shares; o.e_buy = v.buy;
    end else if (v.exec_v || v.del_v) begin
      if (m_live[k] && m_ref[k] == v.oref) begin
        o.e_de = 1; o.e_loc = m_loc[k]; o.e_price = m_price[k]; o.e_buy = m_buy[k];
        if (!v.exec_v || v.shares >= m_sh[k]) begin
          o.e_shares = m_sh[k];
          m_live[k]  = 1'b0;
        end else begin
          o.e_shares = v.shares;
          m_sh[k]    = m_sh[k] - v.shares;
        end
      end else begin
        m_miss++;
      end
    end
    o.e_miss = sat16(m_miss); o.e_coll = sat16(m_coll); o.e_err = sat16(m_err);
    return o;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    addValidIn = v.add_v; execValidIn = v.exec_v; delValidIn = v.del_v;
    orderRefIn = v.oref; locateIn = v.loc; priceIn = v.price;
    sharesIn = v.shares; buySellIn = v.buy;
  endtask

  task automatic check_vec(input vec_t v, input string nm, input int idx);
    string p = $sformatf("%s[%0d]", nm, idx);
    n_vec++;
    cmp({p, ".addValidOut"}, 64'(addValidOut), 64'(v.e_add));
    cmp({p, ".delExecValidOut"}, 64'(delExecValidOut), 64'(v.e_de));
    if (v.e_add) begin
      cmp({p, ".locateOut"}, 64'(locateOut), 64'(v.e_loc));
      cmp({p, ".priceOut"}, 64'(priceOut), 64'(v.e_price));
      cmp({p, ".sharesOut"}, 64'(sharesOut), 64'(v.e_shares));
      cmp({p, ".buySellOut"}, 64'(buySellOut), 64'(v.e_buy));
    end
    if (v.e_de) begin
      cmp({p, ".mapLocateOut"}, 64'(mapLocateOut), 64'(v.e_loc));
      cmp({p, ".mapPriceOut"}, 64'(mapPriceOut), 64'(v.e_price));
      cmp({p, ".mapSharesOut"}, 64'(mapSharesOut), 64'(v.e_shares));
      cmp({p, ".mapBuySellOut"}, 64'(mapBuySellOut), 64'(v.e_buy));
    end
    cmp({p, ".missCntOut"}, 64'(missCntOut), 64'(v.e_miss));
    cmp({p, ".collisionCntOut"}, 64'(collisionCntOut), 64'(v.e_coll));
    cmp({p, ".errCntOut"}, 64'(errCntOut), 64'(v.e_err));
  endtask

  // Drives stim back-to-back, one message per cycle; each result is due three edges later.
  task automatic run_stream(input string nm);
    vec_t pend[$];
    vec_t v;
    int   total = stim.size();
    for (int i = 0; i < total + 3; i++) begin
      @(negedge clkIn);
      if (i >= 3) check_vec(pend.pop_front(), nm, i - 3);
      if (i < total) begin
        v = stim[i];
        drive(v);
        pend.push_back(v);
      end else begin
        drive(msg(0, 0, 0, 64'h0, 16'h0, 32'h0, 32'h0, 1'b0));
      end
    end
  endtask

  // Called at the negedge where reset was released; counts cycles until readyOut rises.
  task automatic check_init(input string nm);
    int n = 0;
    while (readyOut !== 1'b1 && n < 64) begin
      cmp({nm, ".addValidOut"}, 64'(addValidOut), 64'h0);
      cmp({nm, ".delExecValidOut"}, 64'(delExecValidOut), 64'h0);
      cmp({nm, ".counters"}, 64'({missCntOut, collisionCntOut, errCntOut}), 64'h0);
      cmp({nm, ".data"}, 64'(|{locateOut, priceOut, sharesOut, buySellOut, mapLocateOut,
                               mapPriceOut, mapSharesOut, mapBuySellOut}), 64'h0);
      @(negedge clkIn);
      n++;
    end
    cmp({nm, ".init_cycles"}, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    vec_t v;
    logic [2:0] m;
    int r;

    rstIn = 1'b1;
    drive(msg(0, 0, 0, 64'h0, 16'h0, 32'h0, 32'h0, 1'b0));
    repeat (3) @(negedge clkIn);
    rstIn = 1'b0;
    check_init("por");

    tbl[0]  = expect_v(msg(1,0,0, 64'h10, 16'd7, 32'd100, 32'd500, 1), 1,0, 7,100,500,1, 0,0,0);
    tbl[1]  = expect_v(msg(0,1,0, 64'h10, 16'd0, 32'd0, 32'd200, 0),   0,1, 7,100,200,1, 0,0,0);
    tbl[2]  = expect_v(msg(0,0,1, 64'h10, 16'd0, 32'd0, 32'd0, 0),     0,1, 7,100,300,1, 0,0,0);
    tbl[3]  = expect_v(msg(1,0,0, 64'h20, 16'd3, 32'd55, 32'd100, 0),  1,0, 3,55,100,0,  0,0,0);
    tbl[4]  = expect_v(msg(0,1,0, 64'h20, 16'd0, 32'd0, 32'd60, 0),    0,1, 3,55,60,0,   0,0,0);
    tbl[5]  = expect_v(msg(0,1,0, 64'h20, 16'd0, 32'd0, 32'd60, 0),    0,1, 3,55,40,0,   0,0,0);
    tbl[6]  = expect_v(msg(0,1,0, 64'h20, 16'd0, 32'd0, 32'd60, 0),    0,0, 0,0,0,0,     1,0,0);
    tbl[7]  = expect_v(msg(0,0,1, 64'h33, 16'd0, 32'd0, 32'd0, 0),     0,0, 0,0,0,0,     2,0,0);
    tbl[8]  = expect_v(msg(1,0,0, 64'h05, 16'd1, 32'd11, 32'd10, 1),   1,0, 1,11,10,1,   2,0,0);
    tbl[9]  = expect_v(msg(1,0,0, 64'h15, 16'd2, 32'd22, 32'd20, 0),   1,0, 2,22,20,0,   2,1,0);
    tbl[10] = expect_v(msg(0,0,1, 64'h05, 16'd0, 32'd0, 32'd0, 0),     0,0, 0,0,0,0,     3,1,0);
    tbl[11] = expect_v(msg(0,0,1, 64'h15, 16'd0, 32'd0, 32'd0, 0),     0,1, 2,22,20,0,   3,1,0);
    tbl[12] = expect_v(msg(1,0,1, 64'h40, 16'd9, 32'd99, 32'd9, 1),    1,0, 9,99,9,1,    3,1,1);
    for (int i = 13; i < 16; i++)
      tbl[i] = expect_v(msg(0,0,0, 64'h0, 16'd0, 32'd0, 32'd0, 0),     0,0, 0,0,0,0,     3,1,1);
    stim.delete();
    foreach (tbl[i]) stim.push_back(tbl[i]);
    run_stream("dir");

    // Reset in the middle of the sweep restarts it from entry 0.
    @(negedge clkIn);
    rstIn = 1'b1;
    @(negedge clkIn);
    rstIn = 1'b0;
    repeat (5) @(negedge clkIn);
    rstIn = 1'b1;
    @(negedge clkIn);
    cmp("midinit.readyOut", 64'(readyOut), 64'h0);
    cmp("midinit.errCntOut", 64'(errCntOut), 64'h0);
    rstIn = 1'b0;
    check_init("midinit");

    // A message in flight when reset hits must never come out.
    drive(msg(1, 0, 0, 64'h7, 16'd4, 32'd44, 32'd4, 1'b1));
    @(negedge clkIn);
    drive(msg(0, 0, 0, 64'h0, 16'h0, 32'h0, 32'h0, 1'b0));
    rstIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkIn);
      cmp($sformatf("drop[%0d].addValidOut", i), 64'(addValidOut), 64'h0);
    end
    rstIn = 1'b0;
    check_init("drop");

    model_clear();
    stim.delete();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      m = 3'b000;
      else if (r < 16) begin
        m = 3'($urandom_range(3, 7));
        if (m == 3'b100) m = 3'b111;
      end
      else if (r < 52) m = 3'b100;
      else if (r < 76) m = 3'b010;
      else             m = 3'b001;
      v = msg(m[2], m[1], m[0],
              (64'($urandom_range(0, 3)) << 60) | 64'($urandom_range(0, 47)),
              16'($urandom), $urandom,
              m[2] ? 32'($urandom_range(1, 200)) : 32'($urandom_range(1, 150)),
              1'($urandom));
      stim.push_back(model_step(v));
    end
    run_stream("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
